// File: rtl/usb_txn_pkg.sv
// Shared types and constants for the USB transaction arbiter.
package usb_txn_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } txn_state_e;

  // Transfer direction as seen by the protocol engine.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // USB device addresses are 7 bits and endpoint numbers 4 bits on the wire.
  localparam int unsigned USB_ADDR_W = 7;
  localparam int unsigned USB_ENDP_W = 4;

  // Fields latched from the winning requester.
  typedef struct packed {
    logic                  rw;
    logic [USB_ADDR_W-1:0] addr;
    logic [USB_ENDP_W-1:0] endp;
  } txn_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [IdxW-1:0]    idx_o,
  output logic               found_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  // Walk offsets from the pointer; ptr_i < NUM_REQ so one subtraction wraps.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr_i} + (IdxW + 1)'(off);
      if (sum >= (IdxW + 1)'(NUM_REQ)) begin
        sum = sum - (IdxW + 1)'(NUM_REQ);
      end
      cand = sum[IdxW-1:0];
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/usb_txn_arbiter.sv
// Round-robin arbiter sharing one USB protocol engine among NUM_REQ clients,
// with a watchdog that aborts the engine if it never reports completion.
module usb_txn_arbiter
  import usb_txn_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 7,  // at most USB_ADDR_W
  parameter int unsigned ENDP_W  = 4,  // at most USB_ENDP_W
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*ENDP_W-1:0] req_endp,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_success,
  output logic                      resp_timeout,
  output logic                      eng_start,
  output logic                      eng_read_write,
  output logic [ADDR_W-1:0]         eng_addr,
  output logic [ENDP_W-1:0]         eng_endp,
  output logic                      eng_abort,
  input  logic                      eng_done,
  input  logic                      eng_success,
  output logic                      busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  txn_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [TmrW-1:0] timer_q, timer_d;
  txn_req_t        fields_q, fields_d;
  logic            success_q, success_d;
  logic            timeout_q, timeout_d;

  logic [IdxW-1:0] pick_idx;
  logic            pick_found;
  logic            expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign expired = (timer_q == TmrW'(TIMEOUT - 1));

  // Next-state: arbitrate in IDLE, run the watchdog in WAIT, rotate priority in RESP.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    fields_d  = fields_q;
    success_d = success_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          idx_d         = pick_idx;
          fields_d.rw   = req_rw[pick_idx];
          fields_d.addr = USB_ADDR_W'(req_addr[pick_idx*ADDR_W +: ADDR_W]);
          fields_d.endp = USB_ENDP_W'(req_endp[pick_idx*ENDP_W +: ENDP_W]);
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (eng_done) begin
          success_d = eng_success;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (expired) begin
          success_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      fields_q  <= '{rw: RW_READ, addr: '0, endp: '0};
      success_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      fields_q  <= fields_d;
      success_q <= success_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decoded from registered state; eng_abort alone also sees eng_done so
  // that a completion landing on the expiry cycle suppresses the abort.
  always_comb begin
    req_ready      = '0;
    resp_valid     = '0;
    resp_success   = 1'b0;
    resp_timeout   = 1'b0;
    eng_start      = (state_q == ISSUE);
    eng_abort      = (state_q == WAIT) && expired && !eng_done;
    busy           = (state_q != IDLE);
    eng_read_write = fields_q.rw;
    eng_addr       = ADDR_W'(fields_q.addr);
    eng_endp       = ENDP_W'(fields_q.endp);
    if (state_q == ISSUE) begin
      req_ready[idx_q] = 1'b1;
    end
    if (state_q == RESP) begin
      resp_valid[idx_q] = 1'b1;
      resp_success      = success_q;
      resp_timeout      = timeout_q;
    end
  end

endmodule

// File: tb/tb_usb_txn_arbiter.sv
// Self-checking bench for usb_txn_arbiter against a transaction-level model.
module tb_usb_txn_arbiter;
  import usb_txn_pkg::*;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int EW = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_l;
  logic [N-1:0]    req_valid, req_rw, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*EW-1:0] req_endp;
  logic            resp_success, resp_timeout, eng_start, eng_read_write, eng_abort;
  logic [AW-1:0]   eng_addr;
  logic [EW-1:0]   eng_endp;
  logic            eng_done, eng_success, busy;

  int checks = 0;
  int passes = 0;
  int m_ptr  = 0;  // model round-robin pointer

  usb_txn_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .ENDP_W  (EW),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .req_valid      (req_valid),
    .req_rw         (req_rw),
    .req_addr       (req_addr),
    .req_endp       (req_endp),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_success   (resp_success),
    .resp_timeout   (resp_timeout),
    .eng_start      (eng_start),
    .eng_read_write (eng_read_write),
    .eng_addr       (eng_addr),
    .eng_endp       (eng_endp),
    .eng_abort      (eng_abort),
    .eng_done       (eng_done),
    .eng_success    (eng_success),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First requester at or after ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // One transaction from IDLE back to IDLE. delay = WAIT cycle index of eng_done,
  // negative or >= TO means the engine never answers.
  task automatic do_txn(input logic [N-1:0] vld, input logic [N-1:0] rw,
                        input logic [N*AW-1:0] addr, input logic [N*EW-1:0] endp,
                        input int delay, input logic succ, input bit hold,
                        input logic [N*AW-1:0] post_addr, output int granted);
    int w, last;
    logic [N-1:0] exp_rdy;
    logic [AW-1:0] ea;
    logic [EW-1:0] ee;
    logic er, exp_succ, exp_to, answered, exp_abort;
    w = model_pick(vld, m_ptr);
    exp_rdy = '0;
    exp_rdy[w] = 1'b1;
    ea = addr[w*AW +: AW];
    ee = endp[w*EW +: EW];
    er = rw[w];
    answered = (delay >= 0) && (delay < TO);
    last = answered ? delay : TO - 1;
    exp_succ = answered ? succ : 1'b0;
    exp_to = !answered;
    req_valid = vld; req_rw = rw; req_addr = addr; req_endp = endp;
    eng_done = 1'b0; eng_success = 1'b0;
    step();
    checks++; if (eng_start !== 1'b1) $display("FAIL issue_start got %b want 1", eng_start); else passes++;
    checks++; if (req_ready !== exp_rdy) $display("FAIL issue_ready got %b want %b", req_ready, exp_rdy); else passes++;
    checks++; if (resp_valid !== '0) $display("FAIL issue_resp got %b want 0", resp_valid); else passes++;
    checks++; if (eng_addr !== ea) $display("FAIL issue_addr got %h want %h", eng_addr, ea); else passes++;
    checks++; if (eng_endp !== ee) $display("FAIL issue_endp got %h want %h", eng_endp, ee); else passes++;
    checks++; if (eng_read_write !== er) $display("FAIL issue_rw got %b want %b", eng_read_write, er); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL issue_busy got %b want 1", busy); else passes++;
    granted = -1;
    for (int k = 0; k < N; k++) if (req_ready[k]) granted = k;
    // Client reacts to acceptance; also a stray done during ISSUE must be ignored.
    if (!hold) req_valid[w] = 1'b0;
    req_addr = post_addr; req_rw = ~rw; req_endp = ~endp;
    eng_done = 1'b1; eng_success = ~succ;
    for (int c = 0; c <= last; c++) begin
      step();
      eng_done = (c == delay);
      eng_success = (c == delay) ? succ : ~succ;
      #1;
      exp_abort = (c == TO - 1) && (c != delay);
      checks++; if (eng_abort !== exp_abort) $display("FAIL wait_abort c=%0d got %b want %b", c, eng_abort, exp_abort); else passes++;
      checks++; if (eng_addr !== ea) $display("FAIL wait_addr c=%0d got %h want %h", c, eng_addr, ea); else passes++;
      checks++; if ({eng_start, req_ready, resp_valid} !== '0) $display("FAIL wait_quiet c=%0d got %b want 0", c, {eng_start, req_ready, resp_valid}); else passes++;
    end
    step();
    eng_done = 1'b0; eng_success = 1'b0;
    checks++; if (resp_valid !== exp_rdy) $display("FAIL resp_valid got %b want %b", resp_valid, exp_rdy); else passes++;
    checks++; if (resp_success !== exp_succ) $display("FAIL resp_success got %b want %b", resp_success, exp_succ); else passes++;
    checks++; if (resp_timeout !== exp_to) $display("FAIL resp_timeout got %b want %b", resp_timeout, exp_to); else passes++;
    checks++; if (eng_abort !== 1'b0) $display("FAIL resp_abort got %b want 0", eng_abort); else passes++;
    m_ptr = (w + 1) % N;
    step();
    checks++; if ({resp_valid, resp_success, resp_timeout, busy} !== '0) $display("FAIL idle_quiet got %b want 0", {resp_valid, resp_success, resp_timeout, busy}); else passes++;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    req_valid = '0; req_rw = '0; req_addr = '0; req_endp = '0;
    eng_done = 1'b0; eng_success = 1'b0;
    step(); step();
    checks++; if ({req_ready, resp_valid, resp_success, resp_timeout} !== '0) $display("FAIL reset_resp got %b want 0", {req_ready, resp_valid, resp_success, resp_timeout}); else passes++;
    checks++; if ({eng_start, eng_abort, busy} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {eng_start, eng_abort, busy}); else passes++;
    checks++; if ({eng_read_write, eng_addr, eng_endp} !== '0) $display("FAIL reset_fields got %h want 0", {eng_read_write, eng_addr, eng_endp}); else passes++;
    rst_l = 1'b1;
    m_ptr = 0;
    step();
  endtask

  task automatic test_fairness();
    int g;
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 4'($urandom), 28'($urandom), 16'($urandom), 2, 1'b1, 1'b1,
             28'($urandom), g);
      checks++; if (g !== i % N) $display("FAIL fair_order i=%0d got %0d want %0d", i, g, i % N); else passes++;
    end
  endtask

  task automatic test_single();
    int g;
    do_txn(4'b0010, {2'b00, RW_WRITE, 1'b0}, 28'h05 << 7, 16'h1 << 4, 1, 1'b1, 1'b0,
           28'h05 << 7, g);
    checks++; if (g !== 1) $display("FAIL single_grant got %0d want 1", g); else passes++;
  endtask

  task automatic test_timeout();
    int g1, g2;
    do_txn(4'b0101, 4'b0000, 28'($urandom), 16'($urandom), -1, 1'b1, 1'b1, 28'($urandom), g1);
    do_txn(4'b0101, 4'b1111, 28'($urandom), 16'($urandom), 0, 1'b1, 1'b0, 28'($urandom), g2);
    checks++; if (g1 === g2) $display("FAIL timeout_next got %0d want other than %0d", g2, g1); else passes++;
  endtask

  task automatic test_collision();
    int g;
    do_txn(4'b1000, 4'b1000, 28'($urandom), 16'($urandom), TO - 1, 1'b0, 1'b0,
           28'($urandom), g);
  endtask

  task automatic test_reset_mid_wait();
    int g;
    req_valid = 4'b1000; req_addr = 28'h0abcdef; req_endp = 16'h9876; req_rw = 4'b1000;
    step();
    req_valid = '0;
    step(); step();
    rst_l = 1'b0;
    req_valid = 4'b0100;
    step();
    checks++; if ({req_ready, resp_valid, resp_success, resp_timeout} !== '0) $display("FAIL midrst_resp got %b want 0", {req_ready, resp_valid, resp_success, resp_timeout}); else passes++;
    checks++; if ({eng_start, eng_abort, busy, eng_read_write, eng_addr, eng_endp} !== '0) $display("FAIL midrst_eng got %h want 0", {eng_start, eng_abort, busy, eng_read_write, eng_addr, eng_endp}); else passes++;
    rst_l = 1'b1;
    m_ptr = 0;
    do_txn(4'b0100, 4'($urandom), 28'($urandom), 16'($urandom), 2, 1'b1, 1'b0,
           28'($urandom), g);
    checks++; if (g !== 2) $display("FAIL midrst_grant got %0d want 2", g); else passes++;
  endtask

  task automatic test_field_stability();
    int g;
    do_txn(4'b0001, 4'b0000, 28'h05, 16'h3, 3, 1'b1, 1'b0, {4{7'h33}}, g);
    req_valid = '0;
    eng_done = 1'b1; eng_success = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({resp_valid, busy, eng_abort} !== '0) $display("FAIL stray_done i=%0d got %b want 0", i, {resp_valid, busy, eng_abort}); else passes++;
    end
    eng_done = 1'b0; eng_success = 1'b0;
  endtask

  task automatic test_random();
    int g, d;
    for (int i = 0; i < 20; i++) begin
      d = int'($urandom_range(0, TO + 1));
      if (d >= TO) d = -1;
      do_txn(4'($urandom_range(1, 15)), 4'($urandom), 28'($urandom), 16'($urandom), d,
             1'($urandom), 1'($urandom), 28'($urandom), g);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_timeout();
    test_collision();
    test_reset_mid_wait();
    test_field_stability();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
